// File: rtl/ulpi_phy_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ulpi_phy_responder
//  Purpose  : PHY-side ULPI responder for loopback bring-up. It answers link
//             TXCMD register writes/reads from a small register file, emits
//             RXCMD bytes on line-state / VBUS changes and models the
//             FUNC_CTRL.Reset turnaround sequence.
//  Ports    : CLK_60M, RST_USB      - clock, synchronous active-high reset
//             ULPI_DATA_I           - bus data driven by the link
//             ULPI_DATA_O/_OE       - bus data driven by this PHY / enable
//             ULPI_DIR, ULPI_NXT    - ULPI direction / next strobes
//             ULPI_STP              - ULPI stop from the link
//             LINESTATE, VBUS_STATE - status reported through RXCMD
//             FUNC_CTRL_O, OTG_CTRL_O - live register values
//             PHY_RESET_O           - one-cycle pulse at reset-sequence start
//  Revision : 1.0 - initial release
// ============================================================================
module ulpi_phy_responder #(
  parameter logic [15:0] VENDOR_ID    = 16'h0424,
  parameter logic [15:0] PRODUCT_ID   = 16'h0009,
  parameter int unsigned RESET_CYCLES = 8,
  parameter int unsigned WR_TIMEOUT   = 16
) (
  input  logic       CLK_60M,
  input  logic       RST_USB,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_DIR,
  output logic       ULPI_NXT,
  input  logic       ULPI_STP,
  input  logic [1:0] LINESTATE,
  input  logic [1:0] VBUS_STATE,
  output logic [7:0] FUNC_CTRL_O,
  output logic [7:0] OTG_CTRL_O,
  output logic       PHY_RESET_O
);

  localparam int unsigned CNT_MAX = (RESET_CYCLES > WR_TIMEOUT) ? RESET_CYCLES : WR_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [7:0] c_func_ctrl_rst = 8'h41;
  localparam logic [7:0] c_if_ctrl_rst   = 8'h00;
  localparam logic [7:0] c_otg_ctrl_rst  = 8'h06;
  localparam logic [7:0] c_scratch_rst   = 8'h00;
  localparam logic [5:0] c_addr_ext      = 6'h2F;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CMD_ACK  = 4'd1,
    S_WR_DATA  = 4'd2,
    S_WR_STP   = 4'd3,
    S_RD_TURN  = 4'd4,
    S_RD_DATA  = 4'd5,
    S_RD_BACK  = 4'd6,
    S_RX_TURN  = 4'd7,
    S_RX_DATA  = 4'd8,
    S_RX_BACK  = 4'd9,
    S_RST_HOLD = 4'd10,
    S_RST_BACK = 4'd11
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         addr_q, addr_d;
  logic               rd_q, rd_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         last_q, last_d;
  logic               rxp_q, rxp_d;
  logic [7:0]         func_q, func_d;
  logic [7:0]         ifc_q, ifc_d;
  logic [7:0]         otg_q, otg_d;
  logic [7:0]         scr_q, scr_d;
  logic               dir_q, dir_d;
  logic               nxt_q, nxt_d;
  logic               oe_q, oe_d;
  logic [7:0]         data_q, data_d;
  logic               prst_q, prst_d;

  logic [3:0]         w_line;
  logic [7:0]         w_rd_mux;
  logic               w_rst_trig;

  assign w_line = {VBUS_STATE, LINESTATE};

  // Read mux: aliases return their base register, unmapped space reads zero.
  always_comb begin
    w_rd_mux = 8'h00;
    case (addr_q)
      6'h00:               w_rd_mux = VENDOR_ID[7:0];
      6'h01:               w_rd_mux = VENDOR_ID[15:8];
      6'h02:               w_rd_mux = PRODUCT_ID[7:0];
      6'h03:               w_rd_mux = PRODUCT_ID[15:8];
      6'h04, 6'h05, 6'h06: w_rd_mux = func_q;
      6'h07:               w_rd_mux = ifc_q;
      6'h0A, 6'h0B, 6'h0C: w_rd_mux = otg_q;
      6'h16, 6'h17, 6'h18: w_rd_mux = scr_q;
      default:             w_rd_mux = 8'h00;
    endcase
  end

  // A committed write to FUNC_CTRL or its set alias with bit 5 set starts
  // the PHY reset sequence; the clear alias can never set the bit.
  assign w_rst_trig = ((addr_q == 6'h04) || (addr_q == 6'h05)) && wdata_q[5];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    rxp_d   = rxp_q;
    func_d  = func_q;
    ifc_d   = ifc_q;
    otg_d   = otg_q;
    scr_d   = scr_q;
    data_d  = 8'h00;
    dir_d   = 1'b0;
    nxt_d   = 1'b0;
    oe_d    = 1'b0;
    prst_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ULPI_DATA_I[7]) begin
          // Register TXCMD. The extended-register escape is unsupported and
          // simply holds the block in IDLE without acknowledging it.
          if (ULPI_DATA_I[5:0] != c_addr_ext) begin
            addr_d  = ULPI_DATA_I[5:0];
            rd_d    = ULPI_DATA_I[6];
            state_d = S_CMD_ACK;
          end
        end else if (rxp_q || (w_line != last_q)) begin
          state_d = S_RX_TURN;
        end
      end
      S_CMD_ACK: begin
        if (!rd_q && ULPI_STP) state_d = S_IDLE;
        else if (rd_q)         state_d = S_RD_TURN;
        else                   state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        if (ULPI_STP) begin
          state_d = S_IDLE;
        end else begin
          wdata_d = ULPI_DATA_I;
          cnt_d   = '0;
          state_d = S_WR_STP;
        end
      end
      S_WR_STP: begin
        if (ULPI_STP) begin
          if (w_rst_trig) begin
            func_d  = c_func_ctrl_rst;
            ifc_d   = c_if_ctrl_rst;
            otg_d   = c_otg_ctrl_rst;
            scr_d   = c_scratch_rst;
            cnt_d   = '0;
            state_d = S_RST_HOLD;
          end else begin
            case (addr_q)
              6'h04:   func_d = wdata_q;
              6'h05:   func_d = func_q | wdata_q;
              6'h06:   func_d = func_q & ~wdata_q;
              6'h07:   ifc_d  = wdata_q;
              6'h0A:   otg_d  = wdata_q;
              6'h0B:   otg_d  = otg_q | wdata_q;
              6'h0C:   otg_d  = otg_q & ~wdata_q;
              6'h16:   scr_d  = wdata_q;
              6'h17:   scr_d  = scr_q | wdata_q;
              6'h18:   scr_d  = scr_q & ~wdata_q;
              default: ;
            endcase
            state_d = S_IDLE;
          end
        end else if (cnt_q == CNT_W'(WR_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_TURN: begin
        data_d  = w_rd_mux;
        state_d = S_RD_DATA;
      end
      S_RD_DATA: state_d = S_RD_BACK;
      S_RD_BACK: state_d = S_IDLE;
      S_RX_TURN: begin
        // Report the status seen during the turnaround; any later change is
        // caught by the last-reported comparison once back in IDLE.
        data_d  = {4'b0000, w_line};
        last_d  = w_line;
        rxp_d   = 1'b0;
        state_d = S_RX_DATA;
      end
      S_RX_DATA: state_d = S_RX_BACK;
      S_RX_BACK: state_d = S_IDLE;
      S_RST_HOLD: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          rxp_d   = 1'b1;
          state_d = S_RST_BACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RST_BACK: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Pin values are decoded from the next state so they are registered
    // alongside it and line up with the state they belong to.
    case (state_d)
      S_CMD_ACK, S_WR_DATA:             nxt_d = 1'b1;
      S_RD_TURN, S_RX_TURN, S_RST_HOLD: dir_d = 1'b1;
      S_RD_DATA, S_RX_DATA: begin
        dir_d = 1'b1;
        oe_d  = 1'b1;
      end
      default: ;
    endcase
    prst_d = (state_d == S_RST_HOLD) && (state_q != S_RST_HOLD);
  end

  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      rxp_q   <= 1'b1;
      func_q  <= c_func_ctrl_rst;
      ifc_q   <= c_if_ctrl_rst;
      otg_q   <= c_otg_ctrl_rst;
      scr_q   <= c_scratch_rst;
      dir_q   <= 1'b0;
      nxt_q   <= 1'b0;
      oe_q    <= 1'b0;
      data_q  <= 8'h00;
      prst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rxp_q   <= rxp_d;
      func_q  <= func_d;
      ifc_q   <= ifc_d;
      otg_q   <= otg_d;
      scr_q   <= scr_d;
      dir_q   <= dir_d;
      nxt_q   <= nxt_d;
      oe_q    <= oe_d;
      data_q  <= data_d;
      prst_q  <= prst_d;
    end
  end

  assign ULPI_DATA_O  = data_q;
  assign ULPI_DATA_OE = oe_q;
  assign ULPI_DIR     = dir_q;
  assign ULPI_NXT     = nxt_q;
  assign FUNC_CTRL_O  = func_q;
  assign OTG_CTRL_O   = otg_q;
  assign PHY_RESET_O  = prst_q;

endmodule
`default_nettype wire

// File: tb/tb_ulpi_phy_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ulpi_phy_responder
//  Purpose  : Self-checking bench for ulpi_phy_responder. A link-side driver
//             issues register accesses and status changes; a reference model
//             of the register map pushes expected bus bytes into a queue and
//             a monitor pops them whenever the PHY drives the bus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ulpi_phy_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       oe, dir, nxt, stp;
  logic [1:0] ls, vb;
  logic [7:0] func_o, otg_o;
  logic       prst;

  always #8 clk = ~clk;

  ulpi_phy_responder dut (
    .CLK_60M     (clk),
    .RST_USB     (rst),
    .ULPI_DATA_I (data_i),
    .ULPI_DATA_O (data_o),
    .ULPI_DATA_OE(oe),
    .ULPI_DIR    (dir),
    .ULPI_NXT    (nxt),
    .ULPI_STP    (stp),
    .LINESTATE   (ls),
    .VBUS_STATE  (vb),
    .FUNC_CTRL_O (func_o),
    .OTG_CTRL_O  (otg_o),
    .PHY_RESET_O (prst)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         pulses_seen = 0;
  int         pulses_exp  = 0;

  // Reference register model
  logic [7:0] m_func, m_ifc, m_otg, m_scr;
  logic [3:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [5:0] a);
    case (a)
      6'h00: return 8'h24;
      6'h01: return 8'h04;
      6'h02: return 8'h09;
      6'h03: return 8'h00;
      6'h04, 6'h05, 6'h06: return m_func;
      6'h07: return m_ifc;
      6'h0A, 6'h0B, 6'h0C: return m_otg;
      6'h16, 6'h17, 6'h18: return m_scr;
      default: return 8'h00;
    endcase
  endfunction

  // Any reset restores defaults and forces a fresh status report.
  task automatic model_reset();
    m_func = 8'h41; m_ifc = 8'h00; m_otg = 8'h06; m_scr = 8'h00;
    m_last = {vb, ls};
    exp_q.push_back({4'h0, vb, ls});
  endtask

  task automatic model_write(input logic [5:0] a, input logic [7:0] d);
    if ((a == 6'h04 || a == 6'h05) && d[5]) begin
      pulses_exp++;
      model_reset();
      return;
    end
    case (a)
      6'h04: m_func = d;
      6'h05: m_func = m_func | d;
      6'h06: m_func = m_func & ~d;
      6'h07: m_ifc  = d;
      6'h0A: m_otg  = d;
      6'h0B: m_otg  = m_otg | d;
      6'h0C: m_otg  = m_otg & ~d;
      6'h16: m_scr  = d;
      6'h17: m_scr  = m_scr | d;
      6'h18: m_scr  = m_scr & ~d;
      default: ;
    endcase
  endtask

  // Monitor: every byte the PHY drives must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && dir && oe) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bus_unexpected: got 0x%02h, want no bus byte", data_o);
      end else begin
        check("bus_byte", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
      end
    end
    if (!rst && prst) pulses_seen++;
  end

  task automatic wait_nxt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (nxt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL nxt_timeout: got no NXT, want NXT within 100 cycles");
    end
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (!dir && !nxt) q++;
      else q = 0;
    end
    if (q < 4) begin
      tests++;
      fails++;
      $display("FAIL quiet_timeout: got bus busy, want idle within 300 cycles");
    end
  endtask

  // mode 0: normal STP at c3; 1: STP in WR_DATA (abort);
  // 2: no STP for the whole window, late STP after it; 3: STP on last window cycle
  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input int mode);
    bit ok;
    @(posedge clk); #1 data_i = {2'b10, a};
    wait_nxt(ok);
    if (!ok) begin
      data_i = 8'h00;
      return;
    end
    @(posedge clk); #1 data_i = d;
    if (mode == 1) stp = 1'b1;
    @(negedge clk); check("wr_nxt_c2", nxt, 1'b1);
    @(posedge clk); #1 data_i = 8'h00;
    if (mode == 1) begin
      stp = 1'b0;
    end else if (mode == 0) begin
      stp = 1'b1;
      @(negedge clk); check("wr_nxt_c3", nxt, 1'b0);
      @(posedge clk); #1 stp = 1'b0;
      model_write(a, d);
    end else if (mode == 2) begin
      repeat (16) @(posedge clk);
      #1 stp = 1'b1;
      @(posedge clk); #1 stp = 1'b0;
    end else begin
      repeat (15) @(posedge clk);
      #1 stp = 1'b1;
      @(posedge clk); #1 stp = 1'b0;
      model_write(a, d);
    end
  endtask

  task automatic do_read(input logic [5:0] a, input bit chg, input logic [3:0] nl);
    bit ok;
    exp_q.push_back(model_read(a));
    if (chg && nl != m_last) begin
      exp_q.push_back({4'h0, nl});
      m_last = nl;
    end
    @(posedge clk); #1 data_i = {2'b11, a};
    if (chg) {vb, ls} = nl;
    wait_nxt(ok);
    if (!ok) begin
      data_i = 8'h00;
      return;
    end
    @(posedge clk); #1 data_i = 8'h00;
    @(negedge clk); check("rd_c2_dir_oe", {dir, oe}, 2'b10);
    @(negedge clk); check("rd_c3_dir_oe", {dir, oe}, 2'b11);
    @(negedge clk); check("rd_c4_dir", dir, 1'b0);
  endtask

  task automatic set_line(input logic [3:0] nl);
    @(posedge clk); #1 {vb, ls} = nl;
    if (nl != m_last) begin
      exp_q.push_back({4'h0, nl});
      m_last = nl;
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_func"}, func_o, m_func);
    check({tag, "_otg"}, otg_o, m_otg);
  endtask

  function automatic logic [5:0] pick_addr();
    logic [5:0] tbl [14] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                             6'h07, 6'h0A, 6'h0B, 6'h0C, 6'h16, 6'h17, 6'h18};
    logic [5:0] a;
    if ($urandom_range(0, 9) < 7) a = tbl[$urandom_range(0, 13)];
    else a = 6'($urandom_range(0, 63));
    if (a == 6'h2F) a = 6'h30;
    return a;
  endfunction

  initial begin
    int  n;
    bit  ok;
    bit  saw_nxt;
    rst = 1'b1; data_i = 8'h00; stp = 1'b0; ls = 2'b01; vb = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pins", {dir, nxt, oe, prst}, 4'b0000);
    check("rst_data", data_o, 8'h00);
    check("rst_func", func_o, 8'h41);
    check("rst_otg", otg_o, 8'h06);
    m_func = 8'h41; m_ifc = 8'h00; m_otg = 8'h06; m_scr = 8'h00;
    m_last = 4'hD;
    exp_q.push_back(8'h0D);
    @(posedge clk); #1 rst = 1'b0;
    wait_quiet();

    // OTG_CTRL write/read
    do_write(6'h0A, 8'h5A, 0); wait_quiet();
    check("otg_after_wr", otg_o, 8'h5A);
    do_read(6'h0A, 0, 4'h0); wait_quiet();

    // SCRATCH set/clear aliases, ID read and read-only ID
    do_write(6'h16, 8'h0F, 0); wait_quiet();
    do_write(6'h18, 8'h03, 0); wait_quiet();
    do_read(6'h16, 0, 4'h0); wait_quiet();
    do_read(6'h01, 0, 4'h0); wait_quiet();
    do_write(6'h01, 8'h55, 0); wait_quiet();
    do_read(6'h01, 0, 4'h0); wait_quiet();
    do_write(6'h08, 8'hAA, 0); wait_quiet();
    do_read(6'h08, 0, 4'h0); wait_quiet();

    // FUNC_CTRL.Reset sequence
    do_write(6'h0B, 8'h80, 0); wait_quiet();
    do_write(6'h04, 8'h61, 0);
    @(negedge clk);
    check("phy_reset_pulse", prst, 1'b1);
    check("rst_seq_func", func_o, 8'h41);
    n = 0;
    while (dir && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("rst_dir_cycles", n, 8);
    wait_quiet();
    check_regs("after_phy_rst");

    // Aborted and timed-out writes; write committed on the last window cycle
    do_write(6'h0A, 8'h11, 1); wait_quiet();
    do_read(6'h0A, 0, 4'h0); wait_quiet();
    do_write(6'h16, 8'h77, 2); wait_quiet();
    do_read(6'h16, 0, 4'h0); wait_quiet();
    do_write(6'h07, 8'h3C, 3); wait_quiet();
    do_read(6'h07, 0, 4'h0); wait_quiet();

    // TXCMD wins over a simultaneous line-state change
    do_read(6'h04, 1, {vb, ~ls}); wait_quiet();

    // Ignored TXCMDs: extended register (write/read), NOOP, transmit
    saw_nxt = 1'b0;
    foreach (exp_q[i]) ;
    begin
      logic [7:0] ign [4] = '{8'hAF, 8'hEF, 8'h00, 8'h45};
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1 data_i = ign[k];
        repeat (4) begin
          @(negedge clk);
          if (nxt) saw_nxt = 1'b1;
        end
      end
      @(posedge clk); #1 data_i = 8'h00;
    end
    check("ignored_txcmd_nxt", saw_nxt, 1'b0);
    wait_quiet();

    // Reset asserted together with STP in WR_STP: nothing committed
    do_write(6'h0A, 8'h33, 0); wait_quiet();
    @(posedge clk); #1 data_i = 8'h8B;
    wait_nxt(ok);
    @(posedge clk); #1 data_i = 8'hC0;
    @(posedge clk); #1 data_i = 8'h00; stp = 1'b1; rst = 1'b1;
    @(posedge clk); #1 stp = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("midrst_pins", {dir, nxt, oe, prst}, 4'b0000);
    check("midrst_otg", otg_o, 8'h06);
    model_reset();
    wait_quiet();
    do_read(6'h0A, 0, 4'h0); wait_quiet();

    // Randomised traffic against the model
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 5);
      case (op)
        0, 1: do_read(pick_addr(), 0, 4'h0);
        2, 3: do_write(pick_addr(), 8'($urandom), 0);
        4:    set_line(4'($urandom));
        default: do_write(pick_addr(), 8'($urandom), 1);
      endcase
      wait_quiet();
      check_regs("rand");
    end

    check("queue_drained", exp_q.size(), 0);
    check("phy_reset_pulses", pulses_seen, pulses_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, want finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
